// File: rtl/sha256_pkg.sv
// SHA-256/224 shared constants, FSM state type and round helper functions.
// Imported by the schedule window and the mode core.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROUNDS,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z
    );
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(
        input logic [31:0] x,
        input logic [31:0] y,
        input logic [31:0] z
    );
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // bsig*: upper-case sigma of the round; ssig*: lower-case of the schedule
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_mem.sv
// Sliding 16-word message schedule window; presents W[t..t+R-1] each cycle
// and slides by R words on advance.
module sha256_w_mem
    import sha256_pkg::*;
#(
    parameter int R = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              advance,
    input  logic [511:0]      block,
    output logic [R-1:0][31:0] words
);

    logic [31:0] win [0:15];
    logic [31:0] ext [0:15+R];

    // ext[16+j] may depend on freshly expanded words when R > 2
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            ext[i] = win[i];
        end
        for (int j = 0; j < R; j++) begin
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j]
                      + ssig0(ext[1+j]) + ext[j];
        end
    end

    always_comb begin
        for (int i = 0; i < R; i++) begin
            words[i] = win[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= block[511-32*i -: 32];
            end
        end else if (advance) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= ext[i+R];
            end
        end
    end

endmodule

// File: rtl/sha256_mode_core.sv
// SHA-256 / SHA-224 block compression core with R chained rounds per clock.
// Mode is fixed per message on init; next continues from the chaining value.
module sha256_mode_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init,
    input  logic         next,
    input  logic         mode,
    input  logic [511:0] block,
    output logic         ready,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam int R = ROUNDS_PER_CYCLE;
    localparam logic [6:0] STEP = 7'(R);
    localparam logic [6:0] LAST = 7'(64 - R);

    if (!(R == 1 || R == 2 || R == 4)) begin : g_bad_r
        $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
    end

    state_t state;
    logic [6:0] cnt;
    logic mode_q;
    work_t work;
    work_t hash;
    work_t hash_sum;
    work_t stage [0:R];
    logic [R-1:0][31:0] w_words;
    logic accept;
    logic [255:0] iv;

    assign accept = (state == IDLE) && (init || next);
    assign iv = mode ? IV224 : IV256;

    sha256_w_mem #(
        .R(R)
    ) u_w_mem (
        .clk(clk),
        .reset(reset),
        .load(accept),
        .advance(state == ROUNDS),
        .block(block),
        .words(w_words)
    );

    assign stage[0] = work;

    for (genvar gi = 0; gi < R; gi++) begin : g_round
        logic [5:0] kidx;
        logic [31:0] t1;
        logic [31:0] t2;
        work_t s;
        work_t n;

        assign kidx = cnt[5:0] + 6'(gi);

        always_comb begin
            s = stage[gi];
            t1 = s.h + bsig1(s.e) + ch(s.e, s.f, s.g)
               + K[kidx] + w_words[gi];
            t2 = bsig0(s.a) + maj(s.a, s.b, s.c);
            n.a = t1 + t2;
            n.b = s.a;
            n.c = s.b;
            n.d = s.c;
            n.e = s.d + t1;
            n.f = s.e;
            n.g = s.f;
            n.h = s.g;
        end

        assign stage[gi+1] = n;
    end

    always_comb begin
        hash_sum.a = hash.a + work.a;
        hash_sum.b = hash.b + work.b;
        hash_sum.c = hash.c + work.c;
        hash_sum.d = hash.d + work.d;
        hash_sum.e = hash.e + work.e;
        hash_sum.f = hash.f + work.f;
        hash_sum.g = hash.g + work.g;
        hash_sum.h = hash.h + work.h;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ready        <= 1'b1;
            digest_valid <= 1'b0;
            digest       <= '0;
            hash         <= '0;
            work         <= '0;
            cnt          <= '0;
            mode_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (init || next) begin
                        // init restarts from the IV; next chains from H
                        if (init) begin
                            mode_q <= mode;
                            hash   <= iv;
                            work   <= iv;
                        end else begin
                            work   <= hash;
                        end
                        cnt          <= '0;
                        digest_valid <= 1'b0;
                        ready        <= 1'b0;
                        state        <= ROUNDS;
                    end
                end
                ROUNDS: begin
                    work <= stage[R];
                    cnt  <= cnt + STEP;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    hash <= hash_sum;
                    digest <= mode_q ? {hash_sum[255:32], 32'h0}
                                     : hash_sum;
                    digest_valid <= 1'b1;
                    ready        <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_mode_core.sv
// Scoreboard bench for sha256_mode_core at R = 1, 2 and 4.
// Stimulus pushes expected digests; a monitor checks each completion.
module tb_sha256_mode_core;

    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TWO1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO2 = {480'h0, 32'h000001c0};

    localparam logic [255:0] D256 =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D224 = {
        224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7,
        32'h0
    };
    localparam logic [255:0] DMID =
        256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
    localparam logic [255:0] DFIN =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

    typedef struct {
        logic [255:0] dig;
        int acc;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic [2:0] rst;
    logic [2:0] ini;
    logic [2:0] nxt;
    logic mode;
    logic [511:0] block;
    logic [2:0] rdy;
    logic [2:0] dv;
    logic [255:0] dg [3];

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha256_mode_core #(.ROUNDS_PER_CYCLE(1)) u_r1 (
        .clk(clk), .reset(rst[0]), .init(ini[0]), .next(nxt[0]),
        .mode(mode), .block(block), .ready(rdy[0]),
        .digest(dg[0]), .digest_valid(dv[0])
    );
    sha256_mode_core #(.ROUNDS_PER_CYCLE(2)) u_r2 (
        .clk(clk), .reset(rst[1]), .init(ini[1]), .next(nxt[1]),
        .mode(mode), .block(block), .ready(rdy[1]),
        .digest(dg[1]), .digest_valid(dv[1])
    );
    sha256_mode_core #(.ROUNDS_PER_CYCLE(4)) u_r4 (
        .clk(clk), .reset(rst[2]), .init(ini[2]), .next(nxt[2]),
        .mode(mode), .block(block), .ready(rdy[2]),
        .digest(dg[2]), .digest_valid(dv[2])
    );

    function automatic int qsize(input int d);
        case (d)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic push(input int d, input logic [255:0] dig,
                        input int a, input int lat);
        exp_t e;
        e.dig = dig;
        e.acc = a;
        e.lat = lat;
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic check(input int d);
        exp_t e;
        if (qsize(d) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done dut=%0d digest=%h", d, dg[d]);
            return;
        end
        case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        total++;
        if (dg[d] !== e.dig) begin
            bad++;
            $display("FAIL digest dut=%0d got=%h want=%h", d, dg[d], e.dig);
        end
        total++;
        if (cyc - e.acc != e.lat) begin
            bad++;
            $display("FAIL latency dut=%0d got=%0d want=%0d",
                     d, cyc - e.acc, e.lat);
        end
        total++;
        if (rdy[d] !== 1'b1) begin
            bad++;
            $display("FAIL ready_at_done dut=%0d got=%b want=1", d, rdy[d]);
        end
    endtask

    // monitor: a rising digest_valid is one completed block
    initial begin
        logic [2:0] pdv;
        pdv = 3'b000;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (dv[d] === 1'b1 && pdv[d] !== 1'b1) begin
                    check(d);
                end
            end
            pdv = dv;
        end
    end

    task automatic chk_reset(input int d);
        total++;
        if (rdy[d] !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready dut=%0d got=%b want=1", d, rdy[d]);
        end
        total++;
        if (dv[d] !== 1'b0) begin
            bad++;
            $display("FAIL reset_valid dut=%0d got=%b want=0", d, dv[d]);
        end
        total++;
        if (dg[d] !== 256'h0) begin
            bad++;
            $display("FAIL reset_digest dut=%0d got=%h want=0", d, dg[d]);
        end
    endtask

    task automatic start(input int d, input bit i, input bit n,
                         input bit m, input logic [511:0] b,
                         output int a);
        @(negedge clk);
        block = b;
        mode = m;
        ini[d] = i;
        nxt[d] = n;
        a = cyc + 1;
        @(negedge clk);
        ini[d] = 1'b0;
        nxt[d] = 1'b0;
    endtask

    task automatic wait_idle(input int d, input int budget);
        int n;
        n = 0;
        while (qsize(d) != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (qsize(d) != 0) begin
            total++;
            bad++;
            $display("FAIL timeout dut=%0d pending=%0d want=0", d, qsize(d));
            case (d)
                0: q0.delete();
                1: q1.delete();
                default: q2.delete();
            endcase
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 3'b111;
        ini = 3'b000;
        nxt = 3'b000;
        mode = 1'b0;
        block = '0;
        repeat (3) @(negedge clk);
        rst = 3'b000;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk_reset(d);
        end

        // R=1: SHA-256 abc, then SHA-224 abc
        start(0, 1'b1, 1'b0, 1'b0, ABC, acc);
        push(0, D256, acc, 65);
        wait_idle(0, 200);
        start(0, 1'b1, 1'b0, 1'b1, ABC, acc);
        push(0, D224, acc, 65);
        wait_idle(0, 200);

        // R=1: init and next together -> init wins (IV, fresh mode)
        start(0, 1'b1, 1'b1, 1'b0, ABC, acc);
        push(0, D256, acc, 65);
        wait_idle(0, 200);

        // R=2: init with a new block while busy is ignored
        start(1, 1'b1, 1'b0, 1'b0, ABC, acc);
        push(1, D256, acc, 33);
        repeat (9) @(negedge clk);
        block = TWO1;
        mode = 1'b1;
        ini[1] = 1'b1;
        @(negedge clk);
        ini[1] = 1'b0;
        wait_idle(1, 200);

        // R=4: two-block message, mode on next must be ignored
        start(2, 1'b1, 1'b0, 1'b0, TWO1, acc);
        push(2, DMID, acc, 17);
        wait_idle(2, 200);
        start(2, 1'b0, 1'b1, 1'b1, TWO2, acc);
        push(2, DFIN, acc, 17);
        wait_idle(2, 200);

        // R=1: reset 20 edges into a block, then a fresh abc
        start(0, 1'b1, 1'b0, 1'b0, ABC, acc);
        repeat (19) @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk_reset(0);
        repeat (80) @(negedge clk);
        chk_reset(0);
        start(0, 1'b1, 1'b0, 1'b0, ABC, acc);
        push(0, D256, acc, 65);
        wait_idle(0, 200);

        repeat (5) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (qsize(d) != 0) begin
                total++;
                bad++;
                $display("FAIL leftover dut=%0d pending=%0d want=0",
                         d, qsize(d));
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_mode_core.md
SHA256_MODE_CORE -- requirements
Module: sha256_mode_core

Interface
REQ-001 Parameter: ROUNDS_PER_CYCLE, 1, compression rounds per clock; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 init  in  1  start first block of a new message (pulse).
REQ-005 next  in  1  start a continuation block of the current message (pulse).
REQ-006 mode  in  1  0 = SHA-256, 1 = SHA-224; sampled only with init.
REQ-007 block  in  512  message block, word 0 in [511:480].
REQ-008 ready  out  1  core idle, able to accept init/next.
REQ-009 digest  out  256  current chaining value / final digest.
REQ-010 digest_valid  out  1  digest reflects a completed block.

Function
REQ-011 FSM states: IDLE, ROUNDS, DONE; ready SHALL be 1 only in IDLE.
REQ-012 Accept: the core SHALL accept a start at an edge with ready=1 and init or next high; if both are high, init SHALL win and next SHALL be ignored.
REQ-013 init, next and mode SHALL be ignored while ready=0.
REQ-014 On accept: latch block into the schedule window; clear digest_valid; load a..h from the mode IV (init) or from the current H0..H7 (next); clear round counter; enter ROUNDS.
REQ-015 The mode SHALL be latched on init and held for all subsequent next blocks; mode on next SHALL be ignored.
REQ-016 ROUNDS: each cycle SHALL perform ROUNDS_PER_CYCLE chained rounds with indices t..t+R-1 and advance the counter by R; after 64/R cycles, enter DONE.
REQ-017 DONE (one cycle): H_i += working var (mod 2^32); set digest_valid=1; return to IDLE with ready=1.
REQ-018 Latency: ready and digest_valid SHALL assert at the edge exactly 64/R+1 edges after the accepting edge: 65 for R=1, 33 for R=2, 17 for R=4.
REQ-019 Message schedule: W[t] for t<16 from block; for t>=16, W[t]=s1(W[t-2])+W[t-7]+s0(W[t-15])+W[t-16] mod 2^32, with R new words per cycle.
REQ-020 digest format: SHA-256 = H0..H7 with H0 in [255:224]; SHA-224 = H0..H6 in [255:32] and [31:0] = 0.
REQ-021 digest SHALL hold its value while in IDLE, and SHALL NOT change from DONE until the next DONE.
REQ-022 Changes to block after the accepting edge SHALL NOT affect the result.
REQ-023 All arithmetic SHALL be 32-bit modular; no carry out of any word.

Reset
REQ-024 With reset=1 at an edge, in any state: state=IDLE, ready=1, digest_valid=0, digest=0, H0..H7=0, round counter=0, latched mode=0.
REQ-025 reset mid-operation SHALL abort the block with no partial digest update; the first start after reset SHALL be init.
REQ-026 reset SHALL take priority over init/next in the same cycle.

Structure
REQ-027 Package sha256_pkg SHALL hold: the K[0:63] constant table; IV256 and IV224; the FSM state enum; and the Ch, Maj, S0, S1, s0, s1 functions.
REQ-028 Sub-module sha256_w_mem SHALL hold the 16-word sliding schedule window and emit R words per cycle (load, advance, reset).
REQ-029 The round datapath SHALL be a generate loop of R combinational round stages inside sha256_mode_core.

Verification
REQ-030 R=1, SHA-256, init block "abc" (61626380 0..0 00000018) -> ready at edge 65, digest = BA7816BF8F01CFEA414140DE5DAE2223B00361A396177A9CB410FF61F20015AD.
REQ-031 R=1, mode=1, same block -> digest[255:32] = 23097D223405D8228642A477BDA255B32AADBCE4BDA0B3F7E36C9DA7, [31:0]=0.
REQ-032 R=4, two-block "abcdbcdecdefdefg...nopq", mode=0 on init, mode=1 on next -> intermediate 85E655D6417A17953363376A624CDE5C76E09589CAC5F811CC4B32C1F20E533A, final 248D6A61D20638B8E5C026930C3E6039A33CE45964FF2167F6ECEDD419DB06C1, each ready at edge 17.
REQ-033 R=2, init pulse at edge 10 after accept, with block changed -> ignored; digest still abc result at edge 33.
REQ-034 reset at edge 20 of a block -> next edge ready=1, digest_valid=0, digest=0; a fresh abc init then yields the correct digest.
REQ-035 init and next high together in IDLE, after a prior digest -> IV load (init behaviour), abc digest returned.
